instr_fetch: RTL and testbench

//  Fetch stage sitting directly upstream of the instruction ROM. Owns the 8-bit program

---
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage feeding decode: owns the PC, addresses the instruction ROM, registers the
// returned word behind a valid/ready output slot, with redirect/flush, HALT and a fetch counter.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit                HALT_EN  = 1'b1,
  parameter logic [4:0]        HALT_OPC = 5'b10011
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, out_pc_nxt;
  logic [DATA_W-1:0] out_instr_nxt;
  logic              out_valid_nxt;
  logic [15:0]       fetch_count_nxt;
  logic              slot_free, is_halt_word, accept;

  assign rom_addr     = pc;
  assign halted       = (state == HALT);
  assign slot_free    = !out_valid || out_ready;
  assign is_halt_word = HALT_EN && (rom_data[DATA_W-1 -: 5] == HALT_OPC);
  // A word flushed by redirect is never counted, even if decode was ready for it.
  assign accept       = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      out_valid   <= out_valid_nxt;
      out_instr   <= out_instr_nxt;
      out_pc      <= out_pc_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    out_valid_nxt   = out_valid;
    out_instr_nxt   = out_instr;
    out_pc_nxt      = out_pc;
    fetch_count_nxt = fetch_count;

    if (accept && (fetch_count != '1))
      fetch_count_nxt = fetch_count + 16'd1;

    if (redirect_valid) begin
      pc_nxt        = redirect_target;
      out_valid_nxt = 1'b0;
      state_nxt     = RUN;
    end else begin
      case (state)
        RUN: begin
          if (slot_free) begin
            out_instr_nxt = rom_data;
            out_pc_nxt    = pc;
            out_valid_nxt = 1'b1;
            // HALT word is presented but the PC parks on it.
            if (is_halt_word)
              state_nxt = HALT;
            else
              pc_nxt = pc + ADDR_W'(1);
          end
        end
        HALT: begin
          if (out_valid && out_ready)
            out_valid_nxt = 1'b0;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table plus hand-written
// redirect/HALT/reset sequences; accepted words checked through a scoreboard queue.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        out_ready;

  logic [7:0]  rom_addr, out_pc;
  logic [15:0] rom_data, out_instr, fetch_count;
  logic        out_valid, halted;

  logic [7:0]  rom_addr2, out_pc2;
  logic [15:0] rom_data2, out_instr2, fetch_count2;
  logic        out_valid2, halted2;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned acc_count = 0;
  logic [23:0] sbq[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [7:0] a);
    case (a)
      8'h00:   rom = 16'hC000;
      8'h01:   rom = 16'hC801;
      8'h02:   rom = 16'hD002;
      8'h03:   rom = 16'hD803;
      8'h08:   rom = 16'h2908;
      8'h09:   rom = 16'h689C;
      8'hFE:   rom = 16'h0000;
      8'hFF:   rom = 16'h9800;
      default: rom = 16'h1000 | {8'h00, a};
    endcase
  endfunction

  assign rom_data  = rom(rom_addr);
  assign rom_data2 = rom(rom_addr2);

  instr_fetch #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .HALT_EN(1'b1), .HALT_OPC(5'b10011)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  instr_fetch #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .HALT_EN(1'b0), .HALT_OPC(5'b10011)) dut_nohalt (
    .clk(clk), .reset(reset), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
    .halted(halted2), .fetch_count(fetch_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then wait to the sampling edge.
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [7:0] tg,
                      input logic push, input logic [23:0] pv);
    @(posedge clk);
    #1;
    reset           = r;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tg;
    if (push) sbq.push_back(pv);
    @(negedge clk);
  endtask

  // Scoreboard monitor: every handshake must match the next queued word.
  initial begin
    logic [23:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("fetch_count", {16'h0, fetch_count}, acc_count);
      if (reset) begin
        acc_count = 0;
      end else if (out_valid && out_ready && !redirect_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got accept pc=%h instr=%h, required none", out_pc, out_instr);
        end else begin
          e = sbq.pop_front();
          chk("sb_pc", {24'h0, out_pc}, {24'h0, e[23:16]});
          chk("sb_instr", {16'h0, out_instr}, {16'h0, e[15:0]});
        end
        acc_count++;
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic [7:0]  target;
    logic        ev;
    logic [7:0]  epc;
    logic [15:0] ei;
    logic [7:0]  eaddr;
    logic        eh;
  } vec_t;

  vec_t tbl[23];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 16'hC000, 8'h01, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 16'hC801, 8'h02, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 16'hD002, 8'h03, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 16'hD002, 8'h03, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 16'hD002, 8'h03, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 16'hD002, 8'h03, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 16'hD803, 8'h04, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 16'h1004, 8'h05, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h08, 1'b1, 8'h04, 16'h1004, 8'h05, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h08, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 16'h2908, 8'h09, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h09, 16'h689C, 8'h0A, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'h0A, 16'h100A, 8'h0B, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'hFF, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 16'h9800, 8'hFF, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 16'h9800, 8'hFF, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 16'h9800, 8'hFF, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'hFF, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'hFF, 1'b1};
    tbl[20] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000, 8'hFF, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 16'hC000, 8'h01, 1'b0};

    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      step(1'b0, tbl[i].ready, tbl[i].redir, tbl[i].target,
           tbl[i].ev && tbl[i].ready && !tbl[i].redir, {tbl[i].epc, tbl[i].ei});
      chk($sformatf("v%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i), {24'h0, out_pc}, {24'h0, tbl[i].epc});
        chk($sformatf("v%0d_instr", i), {16'h0, out_instr}, {16'h0, tbl[i].ei});
      end
      chk($sformatf("v%0d_rom_addr", i), {24'h0, rom_addr}, {24'h0, tbl[i].eaddr});
      chk($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, tbl[i].eh});
    end

    // Park in HALT with the HALT word stalled, then reset over it.
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 24'h0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 24'h0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 24'h0);
    chk("halt_stall_valid", {31'h0, out_valid}, 32'd1);
    chk("halt_stall_halted", {31'h0, halted}, 32'd1);
    chk("halt_stall_pc", {24'h0, out_pc}, 32'hFF);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 24'h0);
    step(1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 24'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);
    chk("rst_rom_addr", {24'h0, rom_addr}, 32'h00);
    chk("rst_count", {16'h0, fetch_count}, 32'd0);
    chk("rst_instr", {16'h0, out_instr}, 32'h0);

    // HALT_EN=0 instance wraps through FF; the default instance halts there.
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 24'h0);
    chk("nh_valid0", {31'h0, out_valid2}, 32'd0);
    chk("nh_addr_fe", {24'h0, rom_addr2}, 32'hFE);
    chk("h_addr_fe", {24'h0, rom_addr}, 32'hFE);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, {8'hFE, 16'h0000});
    chk("nh_fe_pc", {24'h0, out_pc2}, 32'hFE);
    chk("nh_fe_instr", {16'h0, out_instr2}, 32'h0000);
    chk("nh_fe_valid", {31'h0, out_valid2}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, {8'hFF, 16'h9800});
    chk("nh_ff_pc", {24'h0, out_pc2}, 32'hFF);
    chk("nh_ff_instr", {16'h0, out_instr2}, 32'h9800);
    chk("nh_ff_halted", {31'h0, halted2}, 32'd0);
    chk("nh_wrap_addr", {24'h0, rom_addr2}, 32'h00);
    chk("h_ff_halted", {31'h0, halted}, 32'd1);
    chk("h_ff_addr", {24'h0, rom_addr}, 32'hFF);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 24'h0);
    chk("nh_00_valid", {31'h0, out_valid2}, 32'd1);
    chk("nh_00_pc", {24'h0, out_pc2}, 32'h00);
    chk("nh_00_instr", {16'h0, out_instr2}, 32'hC000);
    chk("nh_00_halted", {31'h0, halted2}, 32'd0);
    chk("nh_count", {16'h0, fetch_count2}, 32'd2);
    chk("h_after_valid", {31'h0, out_valid}, 32'd0);

    @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
